// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  // Which port the read data returning next cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 8;
  localparam int STAT_W     = 16;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive denied DMA cycles; 'expired' forces the DMA
// ahead of an unlocked CPU once the limit is reached.
module arb_starve_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt;

  // Count denied cycles, hold at the limit, restart when served or idle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = (cnt == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one byte-wide synchronous memory between the
// CPU core and the DMA/sample-loader port. Grants are combinational, reads
// return one cycle after the grant, writes complete on the granting edge.
// Build option: define ARB_STATS_EN to build the 16-bit grant/wait counters;
// without it the stat_* ports are tied to zero.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_lock,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [STAT_W-1:0] stat_cpu_grants,
  output logic [STAT_W-1:0] stat_dma_grants,
  output logic [STAT_W-1:0] stat_dma_wait
);

  logic   cpu_locked;
  owner_t rd_owner;
  logic   dma_starved;
  logic   cpu_win;
  logic   dma_win;
  logic   dma_denied;

  assign dma_denied = dma_req && !dma_win;

  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .inc    (dma_denied),
    .clr    (!dma_denied),
    .expired(dma_starved)
  );

  // Pick this cycle's winner: locked CPU, then starved/uncontested DMA, then CPU.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    if (!reset) begin
      if (cpu_locked && cpu_req) begin
        cpu_win = 1'b1;
      end else if (dma_req && (!cpu_req || dma_starved)) begin
        dma_win = 1'b1;
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end
    end
  end

  assign cpu_gnt = cpu_win;
  assign dma_gnt = dma_win;
  assign mem_en  = cpu_win | dma_win;

  // Steer the winner onto the memory port; an idle bus is driven to zero.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Track the CPU lock and which port owns next cycle's read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_locked <= 1'b0;
      rd_owner   <= OWN_NONE;
    end else begin
      if (cpu_win) begin
        cpu_locked <= cpu_lock;
      end else if (!cpu_req) begin
        cpu_locked <= 1'b0;
      end

      if (cpu_win && !cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (dma_win && !dma_we) begin
        rd_owner <= OWN_DMA;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // Read data goes only to the owning port; the other port sees zero.
  assign cpu_rvalid = !reset && (rd_owner == OWN_CPU);
  assign dma_rvalid = !reset && (rd_owner == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  // Wrapping event counters for grants and DMA wait cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_cpu_grants <= '0;
      stat_dma_grants <= '0;
      stat_dma_wait   <= '0;
    end else begin
      if (cpu_win)    stat_cpu_grants <= stat_cpu_grants + 1'b1;
      if (dma_win)    stat_dma_grants <= stat_dma_grants + 1'b1;
      if (dma_denied) stat_dma_wait   <= stat_dma_wait + 1'b1;
    end
  end
`else
  assign stat_cpu_grants = '0;
  assign stat_dma_grants = '0;
  assign stat_dma_wait   = '0;
`endif

endmodule
